// File: rtl/lab7_pkg.sv
// Shared constants and types for the result packer: frame geometry, packed beat layout
// and the even/odd packer state.
package lab7_pkg;

  localparam int DATA_W          = 16;
  localparam int WORDS_PER_FRAME = 128;
  localparam int BEATS_PER_FRAME = WORDS_PER_FRAME / 2;
  localparam int SUM_W           = DATA_W + $clog2(WORDS_PER_FRAME);
  localparam int CNT_W           = $clog2(WORDS_PER_FRAME);
  localparam int FIFO_DEPTH      = 4;

  typedef struct packed {
    logic                  last;
    logic [2*DATA_W-1:0]   data;
  } beat_t;

  typedef enum logic {
    ST_EVEN = 1'b0,
    ST_ODD  = 1'b1
  } pack_state_e;

  function automatic logic [DATA_W-1:0] maxWord(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO of packed beats. A push while full is accepted only when a pop
// happens on the same edge; a pop while empty is ignored.
module sync_fifo
  import lab7_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  beat_t                    pushData,
  input  logic                     pop,
  output beat_t                    headData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(DEPTH);

  beat_t            r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W:0]   r_count;
  logic             w_doPop;
  logic             w_doPush;

  assign empty    = (r_count == '0);
  assign full     = (r_count == CNT_MAX);
  assign count    = r_count;
  assign headData = r_mem[r_rdPtr];
  assign w_doPop  = pop && !empty;
  assign w_doPush = push && (!full || w_doPop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + PTR_ONE;
      if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_ONE;
      unique case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= pushData;
  end

endmodule

// File: rtl/result_packer.sv
// Packs the 16-bit result burst into 32-bit beats, buffers them for the system bus and
// keeps per-frame sum/max statistics plus a sticky beat-dropped flag.
module result_packer
  import lab7_pkg::*;
(
  input  logic                clk3,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] out_data,
  output logic                out_last,
  output logic                stat_valid,
  output logic [SUM_W-1:0]    frame_sum,
  output logic [DATA_W-1:0]   frame_max,
  output logic                ovf_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS_PER_FRAME - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam int               FCNT_W   = $clog2(FIFO_DEPTH) + 1;

  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_low;
  logic [SUM_W-1:0]  r_accSum;
  logic [DATA_W-1:0] r_accMax;
  logic [SUM_W-1:0]  r_frameSum;
  logic [DATA_W-1:0] r_frameMax;
  logic              r_statValid;
  logic              r_ovf;

  pack_state_e       w_state;
  logic [CNT_W-1:0]  w_cntNext;
  logic              w_latchLow;
  logic              w_push;
  logic              w_frameEnd;
  logic              w_drop;
  beat_t             w_pushBeat;
  beat_t             w_head;
  logic              w_full;
  logic              w_empty;
  logic [FCNT_W-1:0] w_fifoCount;

  // The packer state is the low bit of the word counter.
  always_comb begin
    w_state    = pack_state_e'(r_cnt[0]);
    w_latchLow = 1'b0;
    w_push     = 1'b0;
    w_cntNext  = r_cnt;
    if (in_valid) w_cntNext = r_cnt + CNT_ONE;
    unique case (w_state)
      ST_EVEN: w_latchLow = in_valid;
      ST_ODD:  w_push     = in_valid;
      default: ;
    endcase
  end

  assign w_frameEnd      = in_valid && (r_cnt == CNT_LAST);
  assign w_pushBeat.last = (r_cnt == CNT_LAST);
  assign w_pushBeat.data = {in_data, r_low};
  assign w_drop          = w_push && w_full && !(out_ready && !w_empty);

  always_ff @(posedge clk3 or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_low       <= '0;
      r_accSum    <= '0;
      r_accMax    <= '0;
      r_frameSum  <= '0;
      r_frameMax  <= '0;
      r_statValid <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_cnt       <= w_cntNext;
      r_statValid <= w_frameEnd;
      if (w_latchLow) r_low <= in_data;
      if (w_drop)     r_ovf <= 1'b1;
      if (w_frameEnd) begin
        r_frameSum <= r_accSum + SUM_W'(in_data);
        r_frameMax <= maxWord(r_accMax, in_data);
        r_accSum   <= '0;
        r_accMax   <= '0;
      end else if (in_valid) begin
        r_accSum <= r_accSum + SUM_W'(in_data);
        r_accMax <= maxWord(r_accMax, in_data);
      end
    end
  end

  sync_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk3),
    .rst      (rst),
    .push     (w_push),
    .pushData (w_pushBeat),
    .pop      (out_ready),
    .headData (w_head),
    .full     (w_full),
    .empty    (w_empty),
    .count    (w_fifoCount)
  );

  // Bus outputs are zero-gated so an idle bus reads as 0.
  assign out_valid  = (w_fifoCount != '0);
  assign out_data   = out_valid ? w_head.data : '0;
  assign out_last   = out_valid & w_head.last;
  assign stat_valid = r_statValid;
  assign frame_sum  = r_frameSum;
  assign frame_max  = r_frameMax;
  assign ovf_err    = r_ovf;

endmodule

// File: tb/tb_result_packer.sv
// Directed bench for result_packer: drives result frames, collects accepted beats and
// statistics pulses, and compares them against hand-computed values and a pairing model.
module tb_result_packer;
  import lab7_pkg::*;

  logic        clk3 = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_last;
  logic        stat_valid;
  logic [22:0] frame_sum;
  logic [15:0] frame_max;
  logic        ovf_err;

  int assertCount = 0;
  int failCount   = 0;
  int cyc         = 0;
  bit idleCheck   = 1'b0;

  logic [32:0] gotQ[$];
  logic [32:0] expQ[$];
  int          statCyc[$];
  logic [22:0] statSum[$];
  logic [15:0] statMax[$];

  int          mIdx = 0;
  logic [15:0] mLow = '0;
  int          mSum = 0;
  int          mMax = 0;
  int          eSum = 0;
  int          eMax = 0;

  always #5 clk3 = ~clk3;

  result_packer dut (
    .clk3       (clk3),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .stat_valid (stat_valid),
    .frame_sum  (frame_sum),
    .frame_max  (frame_max),
    .ovf_err    (ovf_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Observation happens on the falling edge, half a cycle away from the sampling edge.
  always @(negedge clk3) begin
    cyc++;
    if (out_valid && out_ready) gotQ.push_back({out_last, out_data});
    if (stat_valid) begin
      statCyc.push_back(cyc);
      statSum.push_back(frame_sum);
      statMax.push_back(frame_max);
    end
    if (idleCheck && !out_valid) checkOutput("idle_out_data", out_data, 32'h0);
  end

  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic rdy);
    @(posedge clk3);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
  endtask

  task automatic modelReset();
    mIdx = 0;
    mLow = '0;
    mSum = 0;
    mMax = 0;
  endtask

  task automatic clearRecords();
    gotQ.delete();
    expQ.delete();
    statCyc.delete();
    statSum.delete();
    statMax.delete();
  endtask

  task automatic sendWord(input logic [15:0] d, input logic rdy);
    applyStimulus(1'b1, d, rdy);
    if (mIdx % 2 == 0) mLow = d;
    else expQ.push_back({(mIdx == WORDS_PER_FRAME - 1), d, mLow});
    mSum += int'(d);
    if (int'(d) > mMax) mMax = int'(d);
    if (mIdx == WORDS_PER_FRAME - 1) begin
      eSum = mSum;
      eMax = mMax;
      mSum = 0;
      mMax = 0;
    end
    mIdx = (mIdx + 1) % WORDS_PER_FRAME;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0, rdy);
  endtask

  task automatic doReset();
    @(posedge clk3);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    repeat (2) @(posedge clk3);
    #1;
    rst = 1'b0;
    modelReset();
    clearRecords();
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_out_valid"},  32'(out_valid),  32'h0);
    checkOutput({tag, "_out_data"},   out_data,        32'h0);
    checkOutput({tag, "_out_last"},   32'(out_last),   32'h0);
    checkOutput({tag, "_stat_valid"}, 32'(stat_valid), 32'h0);
    checkOutput({tag, "_frame_sum"},  32'(frame_sum),  32'h0);
    checkOutput({tag, "_frame_max"},  32'(frame_max),  32'h0);
    checkOutput({tag, "_ovf_err"},    32'(ovf_err),    32'h0);
  endtask

  task automatic checkBeats(input string tag);
    int n;
    checkOutput({tag, "_beat_count"}, 32'(gotQ.size()), 32'(expQ.size()));
    n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_data%0d", tag, i), gotQ[i][31:0], expQ[i][31:0]);
      checkOutput($sformatf("%s_last%0d", tag, i), 32'(gotQ[i][32]), 32'(expQ[i][32]));
    end
  endtask

  task automatic checkPairs(input string tag, input int n);
    checkOutput({tag, "_beat_count"}, 32'(gotQ.size()), 32'(n));
    for (int k = 0; k < n && k < gotQ.size(); k++)
      checkOutput($sformatf("%s_beat%0d", tag, k), gotQ[k][31:0],
                  {16'(2 * k + 1), 16'(2 * k)});
  endtask

  initial begin
    int stepCnt;
    logic rdy;

    // Reset state
    repeat (3) @(posedge clk3);
    @(negedge clk3);
    checkResetOutputs("reset");
    @(posedge clk3);
    #1;
    rst = 1'b0;
    modelReset();
    clearRecords();

    // 1: ramp frame, consumer always ready
    for (int i = 0; i < 128; i++) sendWord(16'(i), 1'b1);
    idle(6, 1'b1);
    @(negedge clk3);
    checkBeats("t1");
    checkOutput("t1_beat0", gotQ[0][31:0], 32'h0001_0000);
    checkOutput("t1_beat63", gotQ[63][31:0], 32'h007F_007E);
    checkOutput("t1_last63", 32'(gotQ[63][32]), 32'h1);
    checkOutput("t1_frame_sum", 32'(frame_sum), 32'd8128);
    checkOutput("t1_frame_max", 32'(frame_max), 32'd127);
    checkOutput("t1_stat_pulses", 32'(statCyc.size()), 32'd1);
    checkOutput("t1_ovf", 32'(ovf_err), 32'h0);

    // 2: ramp frame, consumer never ready
    doReset();
    for (int i = 0; i < 128; i++) sendWord(16'(i), 1'b0);
    idle(3, 1'b0);
    @(negedge clk3);
    checkOutput("t2_accepted", 32'(gotQ.size()), 32'd0);
    checkOutput("t2_out_valid", 32'(out_valid), 32'h1);
    checkOutput("t2_head", out_data, 32'h0001_0000);
    checkOutput("t2_ovf", 32'(ovf_err), 32'h1);
    checkOutput("t2_frame_sum", 32'(frame_sum), 32'd8128);
    checkOutput("t2_frame_max", 32'(frame_max), 32'd127);
    idle(8, 1'b1);
    @(negedge clk3);
    checkPairs("t2_drain", 4);
    checkOutput("t2_drained_valid", 32'(out_valid), 32'h0);
    checkOutput("t2_drained_data", out_data, 32'h0);
    checkOutput("t2_ovf_sticky", 32'(ovf_err), 32'h1);

    // 3: full FIFO, pop coincides with the 5th beat
    doReset();
    for (int i = 0; i < 9; i++) sendWord(16'(i), 1'b0);
    sendWord(16'd9, 1'b1);
    idle(2, 1'b0);
    @(negedge clk3);
    checkOutput("t3_accepted", 32'(gotQ.size()), 32'd1);
    checkOutput("t3_ovf", 32'(ovf_err), 32'h0);
    checkOutput("t3_head", out_data, 32'h0003_0002);
    idle(8, 1'b1);
    @(negedge clk3);
    checkPairs("t3_all", 5);
    checkOutput("t3_drained_valid", 32'(out_valid), 32'h0);
    checkOutput("t3_ovf_after", 32'(ovf_err), 32'h0);

    // 4: two back-to-back frames of 0xFFFF
    doReset();
    for (int i = 0; i < 256; i++) sendWord(16'hFFFF, 1'b1);
    idle(6, 1'b1);
    @(negedge clk3);
    checkBeats("t4");
    checkOutput("t4_stat_pulses", 32'(statCyc.size()), 32'd2);
    if (statCyc.size() >= 2) begin
      checkOutput("t4_sum0", 32'(statSum[0]), 32'h007F_FF80);
      checkOutput("t4_sum1", 32'(statSum[1]), 32'h007F_FF80);
      checkOutput("t4_max0", 32'(statMax[0]), 32'h0000_FFFF);
      checkOutput("t4_max1", 32'(statMax[1]), 32'h0000_FFFF);
      checkOutput("t4_spacing", 32'(statCyc[1] - statCyc[0]), 32'd128);
    end

    // 5: gapped random words, random ready (at least one ready slot every 4 cycles)
    doReset();
    idleCheck = 1'b1;
    stepCnt = 0;
    for (int i = 0; i < 128; i++) begin
      rdy = (stepCnt % 4 == 0) || ($urandom_range(0, 1) == 1);
      stepCnt++;
      sendWord(16'($urandom_range(0, 65535)), rdy);
      for (int g = $urandom_range(1, 3); g > 0; g--) begin
        rdy = (stepCnt % 4 == 0) || ($urandom_range(0, 1) == 1);
        stepCnt++;
        applyStimulus(1'b0, 16'h0, rdy);
      end
    end
    idle(8, 1'b1);
    @(negedge clk3);
    idleCheck = 1'b0;
    checkBeats("t5");
    checkOutput("t5_frame_sum", 32'(frame_sum), 32'(eSum));
    checkOutput("t5_frame_max", 32'(frame_max), 32'(eMax));
    checkOutput("t5_stat_pulses", 32'(statCyc.size()), 32'd1);
    checkOutput("t5_ovf", 32'(ovf_err), 32'h0);

    // 6: reset after word 37 with a stalled, overflowed FIFO
    clearRecords();
    modelReset();
    for (int i = 0; i < 38; i++) sendWord(16'(i + 100), 1'b0);
    @(negedge clk3);
    checkOutput("t6_pre_valid", 32'(out_valid), 32'h1);
    checkOutput("t6_pre_ovf", 32'(ovf_err), 32'h1);
    @(posedge clk3);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk3);
    checkResetOutputs("t6_rst");
    @(posedge clk3);
    #1;
    rst = 1'b0;
    modelReset();
    clearRecords();
    for (int i = 0; i < 128; i++) sendWord(16'(3 * i), 1'b1);
    idle(6, 1'b1);
    @(negedge clk3);
    checkBeats("t6");
    checkOutput("t6_beat0", gotQ[0][31:0], 32'h0003_0000);
    checkOutput("t6_frame_sum", 32'(frame_sum), 32'd24384);
    checkOutput("t6_frame_max", 32'(frame_max), 32'd381);
    checkOutput("t6_stat_pulses", 32'(statCyc.size()), 32'd1);
    checkOutput("t6_ovf", 32'(ovf_err), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
